tx_link_sequencer: RTL and testbench
====================================

Name: tx_link_sequencer

Overview:
- Transmit-side controller that drives the `control_dk` / `tx_DataE` inputs of the transmisor (mux + byte_striping) datapath.
- Accepts byte packets from an upper-layer source over a valid/ready handshake and frames them as STP/SDP … END.
- Fills gaps with IDLE and periodically inserts a lane-aligned SKP ordered set (COM + SKP×N).
- Nullifies a packet with EDB on source underflow.

Parameters:
- LANES, 4, number of lanes striped downstream; ordered sets start at symbol phase 0 mod LANES.
- SKP_INTERVAL, 64, enabled cycles between ordered-set requests.
- SKP_COUNT, 3, SKP symbols following each COM.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous reset, active-high
- enb  input  1  global enable; 0 freezes the block
- pkt_valid  input  1  source has a byte (or packet start) available
- pkt_ready  output  1  byte accepted this cycle when pkt_valid & pkt_ready
- pkt_data  input  8  packet byte
- pkt_last  input  1  qualifies the final byte of a packet
- pkt_type  input  1  sampled at packet start: 0 = TLP (STP), 1 = DLLP (SDP)
- control_dk  output  4  symbol select to the mux
- tx_DataE  output  8  data byte to the mux
- skp_pending  output  1  ordered-set request outstanding
- os_active  output  1  ordered set (COM/SKP) being emitted

Behaviour:
- Symbol encoding on control_dk (fixed): 0000 DATA, 0001 COM, 0010 SKP, 0011 STP, 0100 SDP, 0101 END, 0110 EDB, 1000 IDLE.
- tx_DataE = pkt_data byte for DATA symbols; 8'h00 for all K symbols.
- Reset (async, any time):
  - control_dk = 1000, tx_DataE = 8'h00, pkt_ready = 0, skp_pending = 0, os_active = 0.
  - State = S_IDLE, phase = 0, skp counter = 0, SKP counter = 0.
  - Reset mid-packet drops the packet with no END/EDB.
- Outputs are registered: a symbol chosen at edge n is visible during cycle n+1. pkt_ready is a function of the registered state only.
- enb = 0: all registers hold, pkt_ready = 0, and no handshake occurs.
- phase counter: increments mod LANES on every enabled edge. The symbol loaded at an edge carries the pre-increment phase.
- skp counter: increments on every enabled edge. On reaching SKP_INTERVAL-1 it sets skp_pending and restarts at 0. skp_pending clears when COM is loaded. A second expiry while pending is absorbed (no queuing).
- FSM states:
  - S_IDLE:
    - skp_pending and phase == 0: load COM, go to S_SKP.
    - skp_pending and phase != 0: load IDLE and stay (alignment). New packets are blocked while skp_pending.
    - else pkt_valid: load STP (pkt_type = 0) or SDP (pkt_type = 1), go to S_DATA. No byte is consumed here.
    - else: load IDLE.
  - S_SKP: load SKP; after SKP_COUNT loads, go to S_IDLE. os_active = 1 while COM/SKP symbols are on the output.
  - S_DATA: pkt_ready = 1.
    - pkt_valid = 1: load DATA with pkt_data. If pkt_last, go to S_END.
    - pkt_valid = 0 (underflow): load EDB, go to S_IDLE. The source must drop the rest of the packet; bytes presented later start a new packet.
  - S_END: load END, go to S_IDLE. pkt_ready = 0.
- Packet of N bytes produces N+2 consecutive symbols: STP/SDP, D0..DN-1, END. The first symbol appears 1 cycle after pkt_valid is sampled in S_IDLE.
- An ordered set never interrupts a packet. A pending request waits for S_IDLE, then for phase 0.
- Back-to-back packets: after END, S_IDLE may start the next packet on the following edge (one IDLE-free gap is allowed: END is immediately followed by STP).
- A 1-byte packet (pkt_last on the first byte) gives STP, D0, END.

Test Plan:
- Reset then enb = 1, no pkt_valid, SKP_INTERVAL = 64: control_dk = 1000 for the first 64 cycles → COM appears at the first phase-0 slot after skp_pending rises, then 0010×3, skp_pending back to 0.
- pkt_type = 0, 2 bytes AA, BB (last on BB), source always valid: control_dk = 0011, 0000/AA, 0000/BB, 0101 → then 1000; pkt_ready high exactly 2 cycles.
- pkt_type = 1, 10 bytes 00..09: SDP, 10 DATA symbols in order, END; skp_pending rising mid-packet → COM emitted only after END, on a phase-0 symbol, preceded by IDLE padding.
- Underflow: STP, byte 11, then pkt_valid = 0 for one cycle → 0011, 0000/11, 0110 (EDB), then 1000.
- enb = 0 for 5 cycles mid-packet: control_dk/tx_DataE frozen, pkt_ready = 0, counters frozen; resuming continues the byte sequence intact.
- Assert rst during a COM/SKP set: outputs go immediately to 1000/00 with skp_pending = 0; the next ordered set appears SKP_INTERVAL cycles after release.

Source files
------------

// File: rtl/tx_link_sequencer.sv
// Transmit link sequencer: frames upper-layer byte packets as STP/SDP..END,
// pads with IDLE and inserts lane-aligned COM+SKP ordered sets.
module tx_link_sequencer #(
  parameter int LANES        = 4,
  parameter int SKP_INTERVAL = 64,
  parameter int SKP_COUNT    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enb,
  input  logic       pkt_valid,
  output logic       pkt_ready,
  input  logic [7:0] pkt_data,
  input  logic       pkt_last,
  input  logic       pkt_type,
  output logic [3:0] control_dk,
  output logic [7:0] tx_DataE,
  output logic       skp_pending,
  output logic       os_active
);

  localparam int PW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CW = (SKP_INTERVAL > 1) ? $clog2(SKP_INTERVAL) : 1;
  localparam int KW = (SKP_COUNT > 1) ? $clog2(SKP_COUNT) : 1;

  localparam logic [3:0] SYM_DATA = 4'b0000;
  localparam logic [3:0] SYM_COM  = 4'b0001;
  localparam logic [3:0] SYM_SKP  = 4'b0010;
  localparam logic [3:0] SYM_STP  = 4'b0011;
  localparam logic [3:0] SYM_SDP  = 4'b0100;
  localparam logic [3:0] SYM_END  = 4'b0101;
  localparam logic [3:0] SYM_EDB  = 4'b0110;
  localparam logic [3:0] SYM_IDLE = 4'b1000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SKP  = 2'd1,
    S_DATA = 2'd2,
    S_END  = 2'd3
  } state_t;

  state_t        state, state_next;
  logic [PW-1:0] phase, phase_next;
  logic [CW-1:0] skp_cnt, skp_cnt_next;
  logic [KW-1:0] sk_cnt, sk_cnt_next;
  logic          pending_next;
  logic [3:0]    sym_next;
  logic [7:0]    data_next;
  logic          os_next;
  logic          com_load;
  logic          skp_expire;

  assign pkt_ready  = enb & (state == S_DATA);
  assign skp_expire = (skp_cnt == CW'(SKP_INTERVAL - 1));

  always_comb begin
    phase_next   = (phase == PW'(LANES - 1)) ? '0 : phase + 1'b1;
    skp_cnt_next = skp_expire ? '0 : skp_cnt + 1'b1;
    state_next   = state;
    sk_cnt_next  = sk_cnt;
    sym_next     = SYM_IDLE;
    data_next    = 8'h00;
    os_next      = 1'b0;
    com_load     = 1'b0;
    case (state)
      S_IDLE: begin
        // A pending ordered set blocks new packets until it goes out on phase 0
        if (skp_pending) begin
          if (phase == '0) begin
            sym_next    = SYM_COM;
            os_next     = 1'b1;
            com_load    = 1'b1;
            sk_cnt_next = '0;
            state_next  = S_SKP;
          end
        end else if (pkt_valid) begin
          sym_next   = pkt_type ? SYM_SDP : SYM_STP;
          state_next = S_DATA;
        end
      end
      S_SKP: begin
        sym_next = SYM_SKP;
        os_next  = 1'b1;
        if (sk_cnt == KW'(SKP_COUNT - 1)) begin
          sk_cnt_next = '0;
          state_next  = S_IDLE;
        end else begin
          sk_cnt_next = sk_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (pkt_valid) begin
          sym_next  = SYM_DATA;
          data_next = pkt_data;
          if (pkt_last) state_next = S_END;
        end else begin
          sym_next   = SYM_EDB;
          state_next = S_IDLE;
        end
      end
      S_END: begin
        sym_next   = SYM_END;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    // A fresh expiry wins over the clear so a request is never silently lost
    pending_next = skp_expire | (skp_pending & ~com_load);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      phase       <= '0;
      skp_cnt     <= '0;
      sk_cnt      <= '0;
      skp_pending <= 1'b0;
      control_dk  <= SYM_IDLE;
      tx_DataE    <= 8'h00;
      os_active   <= 1'b0;
    end else if (enb) begin
      state       <= state_next;
      phase       <= phase_next;
      skp_cnt     <= skp_cnt_next;
      sk_cnt      <= sk_cnt_next;
      skp_pending <= pending_next;
      control_dk  <= sym_next;
      tx_DataE    <= data_next;
      os_active   <= os_next;
    end
  end

endmodule

// File: tb/tb_tx_link_sequencer.sv
// Directed bench for tx_link_sequencer; enabled-edge numbers in comments count from reset release.
module tb_tx_link_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       enb;
  logic       pkt_valid;
  logic       pkt_ready;
  logic [7:0] pkt_data;
  logic       pkt_last;
  logic       pkt_type;
  logic [3:0] control_dk;
  logic [7:0] tx_DataE;
  logic       skp_pending;
  logic       os_active;

  int n_checks = 0;
  int n_fails  = 0;

  tx_link_sequencer #(.LANES(4), .SKP_INTERVAL(64), .SKP_COUNT(3)) dut (
    .clk(clk), .rst(rst), .enb(enb),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_data(pkt_data),
    .pkt_last(pkt_last), .pkt_type(pkt_type),
    .control_dk(control_dk), .tx_DataE(tx_DataE),
    .skp_pending(skp_pending), .os_active(os_active)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sym(input string tag, input logic [3:0] k, input logic [7:0] d);
    check({tag, " dk"}, 32'(control_dk), 32'(k));
    check({tag, " data"}, 32'(tx_DataE), 32'(d));
  endtask

  task automatic idle_steps(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      step();
      check(tag, 32'(control_dk), 32'h8);
    end
  endtask

  initial begin
    rst = 1'b1; enb = 1'b0; pkt_valid = 1'b0; pkt_data = 8'h00;
    pkt_last = 1'b0; pkt_type = 1'b0;
    #1;
    sym("reset", 4'h8, 8'h00);
    check("reset ready", 32'(pkt_ready), 0);
    check("reset pending", 32'(skp_pending), 0);
    check("reset os", 32'(os_active), 0);
    step();
    rst = 1'b0; enb = 1'b1;

    // Ordered set after 64 idle edges, COM on edge 65 (phase 0)
    idle_steps(63, "idle pre-skp");
    check("pending e63", 32'(skp_pending), 0);
    step();
    check("idle e64", 32'(control_dk), 32'h8);
    check("pending e64", 32'(skp_pending), 1);
    step();
    sym("com e65", 4'h1, 8'h00);
    check("os com", 32'(os_active), 1);
    check("pending cleared", 32'(skp_pending), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      sym("skp", 4'h2, 8'h00);
      check("os skp", 32'(os_active), 1);
    end
    step();
    sym("idle after os", 4'h8, 8'h00);
    check("os off", 32'(os_active), 0);
    $display("ordered set 1 done");

    // TLP AA,BB : edges 70..73
    pkt_valid = 1'b1; pkt_type = 1'b0; pkt_data = 8'hAA; pkt_last = 1'b0;
    check("ready idle", 32'(pkt_ready), 0);
    step();
    sym("stp", 4'h3, 8'h00);
    check("ready d0", 32'(pkt_ready), 1);
    step();
    sym("data AA", 4'h0, 8'hAA);
    check("ready d1", 32'(pkt_ready), 1);
    pkt_data = 8'hBB; pkt_last = 1'b1;
    step();
    sym("data BB", 4'h0, 8'hBB);
    check("ready end", 32'(pkt_ready), 0);
    pkt_valid = 1'b0; pkt_last = 1'b0;
    step();
    sym("end", 4'h5, 8'h00);
    step();
    sym("idle after tlp", 4'h8, 8'h00);
    $display("tlp AA BB done");

    // DLLP 00..09, SDP at edge 120; request rises at edge 128 mid-packet
    idle_steps(45, "idle gap");
    pkt_valid = 1'b1; pkt_type = 1'b1;
    step();
    sym("sdp", 4'h4, 8'h00);
    pkt_type = 1'b0;
    for (int i = 0; i < 10; i++) begin
      pkt_data = 8'(i);
      pkt_last = (i == 9);
      step();
      sym("dllp byte", 4'h0, 8'(i));
      check("dllp no os", 32'(os_active), 0);
      if (i == 7) check("pending mid pkt", 32'(skp_pending), 1);
    end
    pkt_valid = 1'b0; pkt_last = 1'b0;
    step();
    sym("dllp end", 4'h5, 8'h00);
    step();
    sym("align pad", 4'h8, 8'h00);
    check("pending pad", 32'(skp_pending), 1);
    step();
    sym("com e133", 4'h1, 8'h00);
    check("pending cleared 2", 32'(skp_pending), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      sym("skp 2", 4'h2, 8'h00);
    end
    step();
    sym("idle e137", 4'h8, 8'h00);
    $display("dllp 00..09 done");

    // Underflow -> EDB
    pkt_valid = 1'b1; pkt_data = 8'h11;
    step();
    sym("uf stp", 4'h3, 8'h00);
    step();
    sym("uf data", 4'h0, 8'h11);
    pkt_valid = 1'b0;
    step();
    sym("edb", 4'h6, 8'h00);
    step();
    sym("idle after edb", 4'h8, 8'h00);
    $display("underflow packet done");

    // Freeze mid-packet for 5 cycles
    pkt_valid = 1'b1; pkt_data = 8'h21;
    step();
    sym("fz stp", 4'h3, 8'h00);
    step();
    sym("fz d21", 4'h0, 8'h21);
    pkt_data = 8'h22; enb = 1'b0;
    #1;
    check("fz ready low", 32'(pkt_ready), 0);
    for (int i = 0; i < 5; i++) begin
      step();
      sym("frozen", 4'h0, 8'h21);
      check("frozen ready", 32'(pkt_ready), 0);
    end
    enb = 1'b1;
    #1;
    check("resume ready", 32'(pkt_ready), 1);
    step();
    sym("fz d22", 4'h0, 8'h22);
    pkt_data = 8'h23; pkt_last = 1'b1;
    step();
    sym("fz d23", 4'h0, 8'h23);
    pkt_valid = 1'b0; pkt_last = 1'b0;
    step();
    sym("fz end", 4'h5, 8'h00);
    step();
    sym("fz idle", 4'h8, 8'h00);
    $display("freeze packet done");

    // Counters were frozen: next request at enabled edge 192, COM at 193
    idle_steps(44, "idle gap 2");
    check("pending e191", 32'(skp_pending), 0);
    step();
    check("pending e192", 32'(skp_pending), 1);
    step();
    sym("com e193", 4'h1, 8'h00);
    step();
    sym("skp e194", 4'h2, 8'h00);

    // Async reset in the middle of the ordered set
    rst = 1'b1;
    #1;
    sym("async rst", 4'h8, 8'h00);
    check("rst pending", 32'(skp_pending), 0);
    check("rst os", 32'(os_active), 0);
    check("rst ready", 32'(pkt_ready), 0);
    step();
    rst = 1'b0;
    idle_steps(63, "idle post-rst");
    check("pending post-rst e63", 32'(skp_pending), 0);
    step();
    check("pending post-rst e64", 32'(skp_pending), 1);
    step();
    sym("com post-rst", 4'h1, 8'h00);
    check("os post-rst", 32'(os_active), 1);
    $display("reset during ordered set done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
